// File: rtl/map_pkg.sv
// Shared MAP decoder constants and presenter state encoding.
// Frame width here must agree with the decoder's trellis length.
package map_pkg;

   localparam int FRAME_LEN   = 10;
   localparam int HOLD_CYCLES = 16;
   localparam int CNT_W       = 8;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } pres_state_e;

endpackage

// File: rtl/map_frame_assembler_if.sv
// Symbol-in / frame-out bundle between the feeder, the assembler
// and the MAP decoder.
interface map_frame_assembler_if #(
   parameter int FRAME_LEN = map_pkg::FRAME_LEN,
   parameter int CNT_W     = map_pkg::CNT_W
);

   logic                 in_valid;
   logic                 in_ready;
   logic                 in_y1;
   logic                 in_y2;
   logic                 frame_abort;
   logic [FRAME_LEN-1:0] y1_frame;
   logic [FRAME_LEN-1:0] y2_frame;
   logic                 frame_valid;
   logic                 frame_done;
   logic [CNT_W-1:0]     frame_count;

   modport master (
      output in_valid, in_y1, in_y2, frame_abort,
      input  in_ready, y1_frame, y2_frame,
      input  frame_valid, frame_done, frame_count
   );

   modport slave (
      input  in_valid, in_y1, in_y2, frame_abort,
      output in_ready, y1_frame, y2_frame,
      output frame_valid, frame_done, frame_count
   );

endinterface

// File: rtl/map_sym_shift.sv
// Serial-in shadow buffer: collects one frame of (y1,y2) pairs
// and flags it full until the presenter takes it.
module map_sym_shift
   import map_pkg::*;
#(
   parameter int FRAME_LEN = map_pkg::FRAME_LEN
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid_i,
   input  logic                 in_y1_i,
   input  logic                 in_y2_i,
   input  logic                 abort_i,
   input  logic                 load_i,
   output logic [FRAME_LEN-1:0] y1_o,
   output logic [FRAME_LEN-1:0] y2_o,
   output logic                 full_o
);

   localparam int WW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   logic [WW-1:0]        wptr_q, wptr_d;
   logic                 full_q, full_d;
   logic [FRAME_LEN-1:0] y1_q, y1_d;
   logic [FRAME_LEN-1:0] y2_q, y2_d;
   logic                 accept;

   assign accept = in_valid_i & ~full_q;

   always_comb begin
      wptr_d = wptr_q;
      full_d = full_q;
      y1_d   = y1_q;
      y2_d   = y2_q;
      if (full_q) begin
         if (load_i) full_d = 1'b0;
      // abort beats a simultaneous accept: the pair is dropped too
      end else if (abort_i) begin
         wptr_d = '0;
      end else if (accept) begin
         y1_d[wptr_q] = in_y1_i;
         y2_d[wptr_q] = in_y2_i;
         if (wptr_q == WW'(FRAME_LEN-1)) begin
            wptr_d = '0;
            full_d = 1'b1;
         end else begin
            wptr_d = wptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         full_q <= 1'b0;
         y1_q   <= '0;
         y2_q   <= '0;
      end else begin
         wptr_q <= wptr_d;
         full_q <= full_d;
         y1_q   <= y1_d;
         y2_q   <= y2_d;
      end
   end

   assign y1_o   = y1_q;
   assign y2_o   = y2_q;
   assign full_o = full_q;

endmodule

// File: rtl/map_frame_assembler.sv
// Ping-pong frame assembler: fills a shadow frame while the previous
// one is held stable on the decoder inputs for HOLD_CYCLES clocks.
module map_frame_assembler
   import map_pkg::*;
#(
   parameter int FRAME_LEN   = map_pkg::FRAME_LEN,
   parameter int HOLD_CYCLES = map_pkg::HOLD_CYCLES,
   parameter int CNT_W       = map_pkg::CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   map_frame_assembler_if.slave  bus
);

   localparam int HW = $clog2(HOLD_CYCLES);

   pres_state_e          state_q, state_d;
   logic [HW-1:0]        hold_q, hold_d;
   logic [FRAME_LEN-1:0] y1_q, y1_d;
   logic [FRAME_LEN-1:0] y2_q, y2_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [FRAME_LEN-1:0] sh_y1;
   logic [FRAME_LEN-1:0] sh_y2;
   logic                 full;
   logic                 load;
   logic                 hold_last;

   map_sym_shift #(
      .FRAME_LEN (FRAME_LEN)
   ) u_shift (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (bus.in_valid),
      .in_y1_i    (bus.in_y1),
      .in_y2_i    (bus.in_y2),
      .abort_i    (bus.frame_abort),
      .load_i     (load),
      .y1_o       (sh_y1),
      .y2_o       (sh_y2),
      .full_o     (full)
   );

   assign hold_last = (state_q == HOLD) &&
                      (hold_q == HW'(HOLD_CYCLES-1));

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      y1_d    = y1_q;
      y2_d    = y2_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      unique case (state_q)
         IDLE: load = full;
         HOLD: begin
            if (hold_last) begin
               if (full) load = 1'b1;
               else      state_d = IDLE;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // a load restarts the hold window with no gap
      if (load) begin
         state_d = HOLD;
         hold_d  = '0;
         y1_d    = sh_y1;
         y2_d    = sh_y2;
         cnt_d   = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         hold_q  <= '0;
         y1_q    <= '0;
         y2_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         y1_q    <= y1_d;
         y2_q    <= y2_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready    = ~full;
   assign bus.y1_frame    = y1_q;
   assign bus.y2_frame    = y2_q;
   assign bus.frame_valid = (state_q == HOLD);
   assign bus.frame_done  = hold_last;
   assign bus.frame_count = cnt_q;

endmodule

// File: doc/map_frame_assembler.md
Name: map_frame_assembler

Overview:
- Upstream feeder for the 10-step, 4-state MAP decoder.
- Accepts received code-bit pairs (systematic y1, parity y2) serially with a valid/ready handshake and packs them into FRAME_LEN-wide y1/y2 words.
- Presents each completed frame to the decoder, held stable for HOLD_CYCLES clocks while the decoder pipeline settles.
- Ping-pong buffered: the next frame fills while the current one is presented.

Parameters:
- FRAME_LEN, 10, trellis steps per frame; width of y1_frame/y2_frame.
- HOLD_CYCLES, 16, clocks each frame is held on the outputs (covers decoder recursion plus metric pipeline). Must be ≥ 2.
- CNT_W, 8, width of frame_count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream symbol pair valid.
- in_ready  out  1  assembler can accept a pair this cycle.
- in_y1  in  1  systematic hard bit.
- in_y2  in  1  parity hard bit.
- frame_abort  in  1  synchronous discard of the partially filled frame.
- y1_frame  out  FRAME_LEN  presented systematic word; index 0 = first received symbol (trellis time 0).
- y2_frame  out  FRAME_LEN  presented parity word, same ordering.
- frame_valid  out  1  high while a frame is being held for the decoder.
- frame_done  out  1  one-cycle pulse on the last hold cycle of a frame.
- frame_count  out  CNT_W  number of frames presented, modulo 2^CNT_W.

Behaviour:
- Reset (async, rst=1): all outputs 0 except in_ready=1; write pointer 0; shadow empty; presenter IDLE; hold counter 0.
- Accept: on a rising edge with in_valid & in_ready:
  - shadow_y1[wptr] <= in_y1 and shadow_y2[wptr] <= in_y2; wptr increments.
  - If wptr == FRAME_LEN-1: wptr wraps to 0 and shadow_full <= 1.
- in_ready = !shadow_full (combinational from the register). No acceptance while full.
- Presenter FSM, states IDLE and HOLD:
  - IDLE, shadow_full=1: next edge copies shadow into y1_frame/y2_frame, clears shadow_full, hold_cnt <= 0, frame_valid <= 1, frame_count increments, goes to HOLD.
  - HOLD: hold_cnt increments each cycle. frame_done = 1 while hold_cnt == HOLD_CYCLES-1.
  - HOLD, hold_cnt == HOLD_CYCLES-1, shadow_full=1: next edge loads the next frame. frame_valid stays 1 and the state stays HOLD (back-to-back frames, no gap).
  - HOLD, hold_cnt == HOLD_CYCLES-1, shadow_full=0: next edge clears frame_valid and goes to IDLE.
- y1_frame/y2_frame change only on a load edge; otherwise they hold their last value, including in IDLE.
- Latency: the edge that accepts the last pair of a frame sets shadow_full. If the presenter is IDLE, frame_valid rises on the following edge (1 cycle).
- Simultaneous load and accept: in the load cycle shadow_full is still 1, so in_ready=0. in_ready returns to 1 the cycle after the load. No pair is lost or overwritten.
- frame_abort:
  - Takes effect only when shadow_full=0: wptr <= 0 and the partial data is discarded.
  - With shadow_full=1 it is ignored; a completed frame is never dropped.
  - Has no effect on the presenter.
  - If asserted together with an accepted pair, abort wins: the pair is discarded and wptr = 0.
- frame_count wraps from 2^CNT_W-1 to 0.
- Reset mid-frame or mid-hold: everything returns immediately to reset values; partial data is lost.
- No combinational path from in_valid to in_ready.

Decomposition:
- Shared package (map_pkg): FRAME_LEN and HOLD_CYCLES defaults, shared with the decoder so the frame width agrees; presenter state enum {IDLE, HOLD}.
- One natural sub-module, map_sym_shift: serial-in shadow register with wptr, shadow_full and abort logic.
- Presenter FSM, hold counter and output registers stay in the top level.

Test Plan:
- Reset check: hold rst with in_valid=1 → in_ready=1, frame_valid=0, frames=0, frame_count=0. Release rst, send 10 pairs y1=1,0,1,1,0,0,1,0,1,1, y2=0 → after the 10th accepting edge plus 1, y1_frame=10'b1101001101, frame_valid=1, frame_count=1.
- Hold timing: one frame only → frame_valid high exactly 16 cycles; frame_done high only in the 16th; then frame_valid=0 and y1_frame unchanged.
- Back-to-back: stream 30 pairs continuously with in_valid=1 →
  - frames 2 and 3 load on the edges right after frame_done;
  - frame_valid never drops between frames;
  - in_ready is low from each shadow fill until the cycle after its load;
  - frame_count reaches 3 and no pair is dropped (compare to scoreboard).
- Abort: send 4 pairs, assert frame_abort, then send 10 pairs of y1=all ones → presented y1_frame=10'h3FF. Separately, abort asserted while in_ready=0 → the next frame is presented intact.
- Async reset mid-hold: assert rst at hold cycle 5 between clock edges → outputs clear immediately without a clock edge; after release the next full frame presents normally with frame_count=1.
- Wrap: present 256 frames with CNT_W=8 → frame_count returns to 0 on the 256th load.
